// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction fetch unit
package if_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [XLEN-1:0] IF_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush, first-word-fall-through read
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - fetch PC, in-order IMEM reads, decode-side instruction queue
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = IF_RESET_PC,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  input  logic            id_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   discard_q;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   tag_count;
  logic [XLEN-1:0] tag_pc;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            accept;
  logic            resp;
  logic            q_push;
  logic            q_pop;

  // tag_count is the in-flight count, stale responses awaiting discard included.
  assign imem_req  = !reset && !redirect_valid &&
                     (({1'b0, q_count} + {1'b0, tag_count}) < DEPTH_L);
  assign imem_addr = pc_q;
  assign accept    = imem_req && imem_gnt;
  assign resp      = imem_rvalid && (tag_count != '0);
  assign q_push    = resp && (discard_q == '0) && !redirect_valid;

  assign id_valid   = !reset && (q_count != '0);
  assign q_pop      = id_valid && id_ready;
  assign id_pc      = id_valid ? head.pc : '0;
  assign id_instr   = id_valid ? head.instr : '0;
  assign push_entry = '{pc: tag_pc, instr: imem_rdata};

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .push      (accept),
    .push_data (pc_q),
    .pop       (resp),
    .pop_data  (tag_pc),
    .count     (tag_count)
  );

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_instr_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data (push_entry),
    .pop       (q_pop),
    .pop_data  (head),
    .count     (q_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else if (redirect_valid) begin
      pc_q      <= word_align(redirect_pc);
      discard_q <= tag_count - CW'(resp);
    end else begin
      if (accept) pc_q <= pc_q + XLEN'(4);
      if (resp && (discard_q != '0)) discard_q <= discard_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit with queue-based reference model
module tb_if_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_instr;

  logic        w_imem_req, w_id_valid, w_gnt, w_zero;
  logic [31:0] w_imem_addr, w_id_pc, w_id_instr, w_zero32;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .id_ready(id_ready)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_zero), .imem_rdata(w_zero32),
    .redirect_valid(w_zero), .redirect_pc(w_zero32),
    .id_valid(w_id_valid), .id_pc(w_id_pc), .id_instr(w_id_instr), .id_ready(w_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  // IMEM: in-order responses, each request returns lat cycles after acceptance
  typedef struct {logic [31:0] addr; int due;} pend_t;
  pend_t ipend[$];
  int    cyc = 0;
  int    lat = 1;

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (ipend.size() != 0 && ipend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(ipend[0].addr);
      void'(ipend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  end

  // Reference model: delivered entries plus outstanding requests tagged stale on redirect
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  typedef struct {logic [31:0] pc; bit stale;} req_t;
  ent_t        mq[$];
  req_t        mo[$];
  req_t        r;
  logic [31:0] mpc = 32'h0;
  bit          exp_req, exp_valid;
  bit          after_rst = 1'b0;

  initial forever begin
    @(negedge clk);
    exp_req   = !reset && !redirect_valid && (mq.size() + mo.size() < DEPTH);
    exp_valid = !reset && (mq.size() != 0);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (!reset) chk("imem_addr", imem_addr, mpc);
    chk("id_valid", 32'(id_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("id_pc", id_pc, mq[0].pc);
      chk("id_instr", id_instr, mq[0].instr);
    end else if (reset || after_rst) begin
      chk("id_pc_zero", id_pc, 32'h0);
      chk("id_instr_zero", id_instr, 32'h0);
    end

    if (imem_req === 1'b1 && imem_gnt) ipend.push_back('{addr: imem_addr, due: cyc + lat});

    if (reset) begin
      mq.delete();
      mo.delete();
      mpc = 32'h0;
    end else begin
      if (mq.size() != 0 && id_ready) void'(mq.pop_front());
      if (imem_rvalid && mo.size() != 0) begin
        r = mo.pop_front();
        if (!r.stale && !redirect_valid) mq.push_back('{pc: r.pc, instr: instr_of(r.pc)});
      end
      if (redirect_valid) begin
        mq.delete();
        foreach (mo[i]) mo[i].stale = 1'b1;
        mpc = {redirect_pc[31:2], 2'b00};
      end else if (exp_req && imem_gnt) begin
        mo.push_back('{pc: mpc, stale: 1'b0});
        mpc = mpc + 32'd4;
      end
    end
    after_rst = reset;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int acc, late;
  bit got;

  initial begin
    reset = 1'b1; imem_gnt = 1'b0; id_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    w_gnt = 1'b1; w_zero = 1'b0; w_zero32 = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_pc", id_pc, 32'h0);

    // streaming, latency 1, plus the wrapping-PC instance
    @(posedge clk); #1; reset = 1'b0; imem_gnt = 1'b1; id_ready = 1'b1;
    @(negedge clk);
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_valid0", 32'(id_valid), 32'd0);
    chk("wrap_req0", 32'(w_imem_req), 32'd1);
    chk("wrap_addr0", w_imem_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("t1_addr1", imem_addr, 32'h4);
    chk("t1_valid1", 32'(id_valid), 32'd0);
    chk("wrap_addr1", w_imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("t1_addr2", imem_addr, 32'h8);
    chk("t1_valid2", 32'(id_valid), 32'd1);
    chk("t1_pc0", id_pc, 32'h0);
    chk("t1_instr0", id_instr, 32'h1357_9BDF);
    chk("wrap_addr2", w_imem_addr, 32'h0000_0000);
    chk("wrap_valid", 32'(w_id_valid), 32'd0);
    chk("wrap_id_pc", w_id_pc, 32'h0);
    chk("wrap_id_instr", w_id_instr, 32'h0);
    @(negedge clk);
    chk("t1_pc1", id_pc, 32'h4);
    chk("t1_instr1", id_instr, 32'h1357_9BDB);
    @(negedge clk);
    chk("t1_pc2", id_pc, 32'h8);
    repeat (4) @(negedge clk);

    // fill the queue with decode stalled, then drain
    @(posedge clk); #1; reset = 1'b1; id_ready = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) acc++;
    end
    chk("t2_accepts", 32'(acc), 32'd4);
    chk("t2_req_stall", 32'(imem_req), 32'd0);
    chk("t2_head", id_pc, 32'h0);
    @(posedge clk); #1; id_ready = 1'b1;
    @(negedge clk);
    chk("t2_d0", id_pc, 32'h0);
    @(negedge clk);
    chk("t2_d1", id_pc, 32'h4);
    chk("t2_resume_req", 32'(imem_req), 32'd1);
    chk("t2_resume_addr", imem_addr, 32'h10);
    @(negedge clk);
    chk("t2_d2", id_pc, 32'h8);
    @(negedge clk);
    chk("t2_d3", id_pc, 32'hC);
    @(negedge clk);
    chk("t2_d4", id_pc, 32'h10);

    // redirect with two requests in flight
    @(posedge clk); #1; reset = 1'b1; imem_gnt = 1'b0; lat = 5;
    @(posedge clk); #1; reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h20;
    @(posedge clk); #1; redirect_valid = 1'b0; imem_gnt = 1'b1;
    @(negedge clk);
    chk("t3_a0", imem_addr, 32'h20);
    @(negedge clk);
    chk("t3_a1", imem_addr, 32'h24);
    @(posedge clk); #1; imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h103;
    @(negedge clk);
    chk("t3_redir_req", 32'(imem_req), 32'd0);
    @(posedge clk); #1; redirect_valid = 1'b0; imem_gnt = 1'b1;
    @(negedge clk);
    chk("t3_new_req", 32'(imem_req), 32'd1);
    chk("t3_new_addr", imem_addr, 32'h100);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (id_valid) got = 1'b1;
    end
    chk("t3_wait", 32'(got), 32'd1);
    chk("t3_first_pc", id_pc, 32'h100);
    chk("t3_first_instr", id_instr, 32'h1357_9ADF);

    // redirect coinciding with a response and a pop
    @(posedge clk); #1; lat = 1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #2;
      if (imem_rvalid && id_valid) got = 1'b1;
    end
    chk("t4_wait", 32'(got), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    chk("t4_pre_rvalid", 32'(imem_rvalid), 32'd1);
    chk("t4_pre_valid", 32'(id_valid), 32'd1);
    chk("t4_redir_req", 32'(imem_req), 32'd0);
    @(posedge clk); #1; redirect_valid = 1'b0;
    @(negedge clk);
    chk("t4_empty", 32'(id_valid), 32'd0);
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr, 32'h200);
    repeat (6) @(posedge clk);

    // reset with three requests in flight; late responses must be ignored
    #1; reset = 1'b1; imem_gnt = 1'b0; lat = 8;
    @(posedge clk); #1; reset = 1'b0; imem_gnt = 1'b1;
    repeat (3) @(posedge clk);
    #1; imem_gnt = 1'b0; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    late = 0;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      chk("t5_idle", 32'(id_valid), 32'd0);
      if (imem_rvalid && !reset) late++;
      if (ipend.size() == 0 && !imem_rvalid) got = 1'b1;
    end
    chk("t5_drained", 32'(got), 32'd1);
    chk("t5_late", 32'(late), 32'd3);
    @(posedge clk); #1; imem_gnt = 1'b1; lat = 1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (id_valid) got = 1'b1;
    end
    chk("t5_wait", 32'(got), 32'd1);
    chk("t5_first_pc", id_pc, 32'h0);
    chk("t5_first_instr", id_instr, 32'h1357_9BDF);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Consumes the program counter and drives the instruction-memory read port.
- Owns the fetch PC register, issues in-order word reads, and buffers the returned instructions with their PCs in a small queue.
- Delivers PC/instruction pairs to the decode stage over a valid/ready handshake.
- Sits between IMEM and ID. Handles branch/jump redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.
- DEPTH, 4, instruction queue entries and maximum in-flight plus buffered requests; power of 2, minimum 2.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  read request valid
- imem_addr  out  32  word-aligned read address
- imem_gnt  in  1  IMEM accepts the request this cycle
- imem_rvalid  in  1  read data valid; responses return in order, latency ≥1 cycle
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  branch/jump taken, one-cycle pulse
- redirect_pc  in  32  new fetch target
- id_valid  out  1  queue head valid
- id_pc  out  32  PC of head entry
- id_instr  out  32  instruction of head entry
- id_ready  in  1  decode accepts head

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-high.
  - On reset: pc_q=RESET_PC, queue empty, inflight=0, discard=0.
  - All outputs read 0 during and right after reset: imem_req=0, id_valid=0, id_pc=0, id_instr=0.
- Issue condition: imem_req = !reset && !redirect_valid && (count + inflight < DEPTH), where inflight includes responses pending discard. imem_addr=pc_q.
- Request handshake: accepted when imem_req && imem_gnt.
  - pc_q += 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - The request's PC is pushed into an address-tag FIFO.
  - inflight increments.
- Response handling: on imem_rvalid, inflight decrements.
  - If discard>0: discard decrements, the tag is popped, and the data is dropped.
  - Otherwise {tag PC, imem_rdata} is pushed into the queue.
  - Space is always guaranteed by the issue condition.
  - imem_rvalid with inflight==0 is ignored and changes no state.
- Output: id_valid = count!=0; id_pc/id_instr driven combinationally from the head. The head pops when id_valid && id_ready.
- Simultaneous accept, response and pop in the same cycle: all three apply. count' = count + push − pop; inflight' = inflight + accept − resp.
- Redirect (highest priority except reset):
  - pc_q <= {redirect_pc[31:2],2'b00}.
  - Queue is cleared; any pop that cycle is still honoured as consumed.
  - discard <= inflight − (imem_rvalid ? 1 : 0). The same-cycle response is also dropped.
  - No request issues in the redirect cycle. Requests to the new PC issue from the next cycle, behind the pending discards.
- Back-to-back redirects: the later one wins; discard is recomputed from the current inflight count.
- Reset mid-operation: all state is cleared. Responses arriving after reset deassert, with inflight==0, are ignored.
- Throughput: one instruction per cycle when imem_gnt stays high and IMEM latency ≤ DEPTH−1.

Decomposition:
- Shared package if_pkg:
  - XLEN=32
  - INSTR_NOP=32'h0000_0013
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}
  - the default RESET_PC constant
- Sub-module sync_fifo (parameterized width/depth, synchronous active-high reset, flush input). It is instantiated twice: once for the tag FIFO and once for the instruction queue.

Test Plan:
- Reset release, imem_gnt=1, 1-cycle latency, id_ready=1 → imem_addr 0,4,8,…; id_pc 0,4,8 on consecutive cycles with matching id_instr; id_valid first high 2 cycles after first request.
- id_ready=0, DEPTH=4, latency 1 → exactly 4 requests accepted, imem_req drops; queue holds PCs 0,4,8,C. Raise id_ready → drains in order and fetch resumes at 0x10.
- With 2 requests in flight (PCs 0x20, 0x24), pulse redirect_pc=0x103 → next imem_addr=0x100; both stale responses dropped; first id_pc=0x100.
- Redirect in the same cycle as imem_rvalid and id_ready pop → that response dropped, queue empty next cycle, no request in redirect cycle.
- RESET_PC=32'hFFFF_FFF8, gnt held → addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert reset with 3 in flight, then deassert; IMEM returns 3 late responses → all ignored, id_valid=0 until new fetch from RESET_PC returns.
